// File: rtl/pio_irq_servicer.sv
// Avalon-MM initiator servicing an edge-capture PIO slave.
// Programs irq_mask, drains edge_capture and emits event records.
module pio_irq_servicer #(
    parameter int                 WIDTH     = 4,
    parameter logic [WIDTH-1:0]   INIT_MASK = WIDTH'(4'hF),
    parameter int                 CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic [1:0]           avm_address,
    output logic                 avm_chipselect,
    output logic                 avm_write_n,
    output logic [31:0]          avm_writedata,
    input  logic [31:0]          avm_readdata,
    input  logic                 irq,
    input  logic [WIDTH-1:0]     mask_in,
    input  logic                 mask_load,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [WIDTH-1:0]     evt_edges,
    output logic [WIDTH-1:0]     evt_level,
    output logic [CNT_WIDTH-1:0] evt_count,
    output logic                 busy
);

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_MASK = 2'd2;
    localparam logic [1:0] A_EDGE = 2'd3;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD_EDGE,
        S_CAP_EDGE,
        S_CLR,
        S_RD_LVL,
        S_CAP_LVL,
        S_EMIT
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     mask_q;
    logic                 pend_q;
    logic [WIDTH-1:0]     edge_q;
    logic [WIDTH-1:0]     lvl_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 valid_q;
    logic                 busy_q;
    logic [1:0]           addr_q;
    logic                 cs_q;
    logic                 wn_q;
    logic [31:0]          wd_q;

    logic [31:0]          mask_q_ext;
    logic [31:0]          mask_in_ext;
    logic                 unused_rd;

    // Zero-extend the mask values onto the 32-bit write bus.
    always_comb begin
        mask_q_ext               = '0;
        mask_q_ext[WIDTH-1:0]    = mask_q;
        mask_in_ext              = '0;
        mask_in_ext[WIDTH-1:0]   = mask_in;
    end

    assign unused_rd = ^avm_readdata;

    // Controller: bus outputs are registered from the state being entered,
    // so each state's bus cycle is visible while the FSM sits in it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_INIT;
            mask_q  <= INIT_MASK;
            pend_q  <= 1'b0;
            edge_q  <= '0;
            lvl_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            addr_q  <= A_DATA;
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            wd_q    <= '0;
        end else begin
            addr_q <= A_DATA;
            cs_q   <= 1'b0;
            wn_q   <= 1'b1;
            wd_q   <= '0;
            busy_q <= 1'b1;

            if (mask_load && state_q != S_IDLE) begin
                mask_q <= mask_in;
                pend_q <= 1'b1;
            end

            unique case (state_q)
                S_INIT: begin
                    if (wn_q) begin
                        // First cycle out of reset: launch the mask write.
                        cs_q   <= 1'b1;
                        wn_q   <= 1'b0;
                        addr_q <= A_MASK;
                        wd_q   <= mask_q_ext;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (mask_load) begin
                        mask_q  <= mask_in;
                        pend_q  <= 1'b0;
                        state_q <= S_INIT;
                        cs_q    <= 1'b1;
                        wn_q    <= 1'b0;
                        addr_q  <= A_MASK;
                        wd_q    <= mask_in_ext;
                    end else if (pend_q) begin
                        pend_q  <= 1'b0;
                        state_q <= S_INIT;
                        cs_q    <= 1'b1;
                        wn_q    <= 1'b0;
                        addr_q  <= A_MASK;
                        wd_q    <= mask_q_ext;
                    end else if (irq) begin
                        state_q <= S_RD_EDGE;
                        cs_q    <= 1'b1;
                        addr_q  <= A_EDGE;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                S_RD_EDGE: begin
                    state_q <= S_CAP_EDGE;
                end
                S_CAP_EDGE: begin
                    edge_q  <= avm_readdata[WIDTH-1:0] & mask_q;
                    state_q <= S_CLR;
                    cs_q    <= 1'b1;
                    wn_q    <= 1'b0;
                    addr_q  <= A_EDGE;
                end
                S_CLR: begin
                    state_q <= S_RD_LVL;
                    cs_q    <= 1'b1;
                    addr_q  <= A_DATA;
                end
                S_RD_LVL: begin
                    state_q <= S_CAP_LVL;
                end
                S_CAP_LVL: begin
                    lvl_q <= avm_readdata[WIDTH-1:0];
                    if (edge_q == '0) begin
                        // Spurious irq or edges masked away: no record.
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_EMIT;
                        valid_q <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (evt_ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        if (cnt_q != '1)
                            cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wn_q;
    assign avm_writedata  = wd_q;
    assign evt_valid      = valid_q;
    assign evt_edges      = edge_q;
    assign evt_level      = lvl_q;
    assign evt_count      = cnt_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_pio_irq_servicer.sv
// Directed bench for pio_irq_servicer with a behavioural PIO slave.
// Drives and samples on the falling clock edge.
module tb_pio_irq_servicer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = '0;
    logic        irq;
    logic [3:0]  mask_in = '0;
    logic        mask_load = 1'b0;
    logic        evt_valid;
    logic        evt_ready = 1'b1;
    logic [3:0]  evt_edges;
    logic [3:0]  evt_level;
    logic [1:0]  evt_count;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave model state
    logic [3:0]  ec    = '0;
    logic [3:0]  lvl   = '0;
    logic [3:0]  smask = '0;
    logic [3:0]  inj   = '0;
    logic [31:0] last_wd = '0;
    logic [2:0]  log_q[$];

    always #5 clk = ~clk;

    pio_irq_servicer #(
        .WIDTH    (4),
        .INIT_MASK(4'hF),
        .CNT_WIDTH(2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avm_address   (avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write_n   (avm_write_n),
        .avm_writedata (avm_writedata),
        .avm_readdata  (avm_readdata),
        .irq           (irq),
        .mask_in       (mask_in),
        .mask_load     (mask_load),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_edges     (evt_edges),
        .evt_level     (evt_level),
        .evt_count     (evt_count),
        .busy          (busy)
    );

    assign irq = |(ec & smask);

    // Edge-capture PIO slave: registered reads, write-any-clears edges.
    always @(posedge clk) begin
        if (avm_chipselect)
            log_q.push_back({avm_write_n, avm_address});
        if (avm_chipselect && avm_write_n) begin
            case (avm_address)
                2'd0:    avm_readdata <= {28'd0, lvl};
                2'd2:    avm_readdata <= {28'd0, smask};
                2'd3:    avm_readdata <= {28'd0, ec};
                default: avm_readdata <= '0;
            endcase
        end
        if (avm_chipselect && !avm_write_n) begin
            last_wd <= avm_writedata;
            if (avm_address == 2'd2)
                smask <= avm_writedata[3:0];
        end
        if (avm_chipselect && !avm_write_n && avm_address == 2'd3)
            ec <= inj;
        else
            ec <= ec | inj;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge of cycle 0.
    task automatic pulse_edge(input logic [3:0] v);
        inj = v;
        @(negedge clk);
        inj = '0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (evt_valid) break;
            @(negedge clk);
        end
        check(tag, 32'(evt_valid), 32'd1);
    endtask

    bit stable;
    bit saw;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_bus", {avm_chipselect, avm_write_n, avm_address},
              {1'b0, 1'b1, 2'd0});
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_cnt", 32'(evt_count), 32'd0);

        // Reset release: one mask write of 0xF
        reset_n = 1'b1;
        @(negedge clk);
        check("init_wr", {avm_chipselect, avm_write_n, avm_address},
              {1'b1, 1'b0, 2'd2});
        check("init_wd", avm_writedata, 32'h0000_000F);
        @(negedge clk);
        check("init_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        check("init_nwr", 32'(log_q.size()), 32'd1);

        // Basic event: edges 0100, level 1011, latency 6
        log_q.delete();
        lvl = 4'b1011;
        pulse_edge(4'b0100);
        repeat (5) @(negedge clk);
        check("lat_c5", 32'(evt_valid), 32'd0);
        @(negedge clk);
        check("lat_c6", 32'(evt_valid), 32'd1);
        check("e1_edges", 32'(evt_edges), 32'b0100);
        check("e1_level", 32'(evt_level), 32'b1011);
        check("e1_cnt0", 32'(evt_count), 32'd0);
        @(negedge clk);
        check("e1_acc", 32'(evt_valid), 32'd0);
        check("e1_cnt1", 32'(evt_count), 32'd1);
        check("e1_nbus", 32'(log_q.size()), 32'd3);
        if (log_q.size() == 3) begin
            check("e1_bus0", 32'(log_q[0]), 32'h7);
            check("e1_bus1", 32'(log_q[1]), 32'h3);
            check("e1_bus2", 32'(log_q[2]), 32'h4);
        end

        // Backpressure with a coalesced second edge
        @(negedge clk);
        evt_ready = 1'b0;
        lvl = 4'b0101;
        pulse_edge(4'b0010);
        wait_valid("bp_to1", 12);
        log_q.delete();
        stable = 1'b1;
        pulse_edge(4'b0001);
        for (int i = 0; i < 10; i++) begin
            if (!(evt_valid && evt_edges == 4'b0010 &&
                  evt_level == 4'b0101))
                stable = 1'b0;
            @(negedge clk);
        end
        check("bp_hold", 32'(stable), 32'd1);
        check("bp_nbus", 32'(log_q.size()), 32'd0);
        evt_ready = 1'b1;
        @(negedge clk);
        check("bp_acc", 32'(evt_valid), 32'd0);
        check("bp_cnt2", 32'(evt_count), 32'd2);
        wait_valid("bp_to2", 12);
        check("bp_e2", 32'(evt_edges), 32'b0001);
        @(negedge clk);
        check("bp_cnt3", 32'(evt_count), 32'd3);

        // mask_load during RD_LVL: record kept, mask 3 written afterwards
        repeat (2) @(negedge clk);
        lvl = 4'b0000;
        pulse_edge(4'b0010);
        repeat (4) @(negedge clk);
        mask_in = 4'b0011;
        mask_load = 1'b1;
        @(negedge clk);
        mask_load = 1'b0;
        @(negedge clk);
        check("ml_valid", 32'(evt_valid), 32'd1);
        check("ml_edges", 32'(evt_edges), 32'b0010);
        @(negedge clk);
        check("sat_cnt", 32'(evt_count), 32'd3);
        @(negedge clk);
        check("ml_wr", {avm_chipselect, avm_write_n, avm_address},
              {1'b1, 1'b0, 2'd2});
        check("ml_wd", avm_writedata, 32'h3);
        @(negedge clk);
        check("ml_busy", 32'(busy), 32'd0);

        // Bit 3 now masked in slave: no service, no record
        saw = 1'b0;
        pulse_edge(4'b1000);
        for (int i = 0; i < 12; i++) begin
            if (evt_valid || busy) saw = 1'b1;
            @(negedge clk);
        end
        check("m3_quiet", 32'(saw), 32'd0);

        // mask_load in IDLE: immediate write of 0xF
        mask_in = 4'hF;
        mask_load = 1'b1;
        @(negedge clk);
        mask_load = 1'b0;
        check("idle_wr", {avm_chipselect, avm_write_n, avm_address},
              {1'b1, 1'b0, 2'd2});
        check("idle_wd", avm_writedata, 32'hF);
        @(negedge clk);
        // Pending bit 3 edge now raises irq; mask changes before CAP_EDGE
        repeat (10) @(negedge clk);
        ec = '0;
        @(negedge clk);
        log_q.delete();
        pulse_edge(4'b1000);
        @(negedge clk);
        mask_in = 4'b0011;
        mask_load = 1'b1;
        @(negedge clk);
        mask_load = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (evt_valid) saw = 1'b1;
            @(negedge clk);
        end
        check("mc_noevt", 32'(saw), 32'd0);
        check("mc_cnt", 32'(evt_count), 32'd3);
        check("mc_nbus", 32'(log_q.size()), 32'd4);
        if (log_q.size() == 4) begin
            check("mc_clr", 32'(log_q[1]), 32'h3);
            check("mc_mwr", 32'(log_q[3]), 32'h2);
        end
        check("mc_wd", last_wd, 32'h3);

        // Reset while in EMIT
        evt_ready = 1'b0;
        pulse_edge(4'b0001);
        wait_valid("rs_to", 12);
        reset_n = 1'b0;
        #1;
        check("rs_valid", 32'(evt_valid), 32'd0);
        check("rs_cnt", 32'(evt_count), 32'd0);
        check("rs_busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        evt_ready = 1'b1;
        @(negedge clk);
        check("rs_wr", {avm_chipselect, avm_write_n, avm_address},
              {1'b1, 1'b0, 2'd2});
        check("rs_wd", avm_writedata, 32'hF);
        @(negedge clk);
        check("rs_busy0", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pio_irq_servicer.md
Name: pio_irq_servicer

Overview:
Avalon-MM initiator that services a 4-bit edge-capture input PIO slave (regs: 0 = data, 2 = irq_mask, 3 = edge_capture, write-any-clears). After reset it programs the slave's irq_mask. On each slave irq it reads edge_capture, clears it, reads the live input level, and presents one event record downstream over a valid/ready handshake. It sits beside the button PIO so fabric logic can consume button events without HPS software.

Parameters:
WIDTH, 4, number of PIO input bits serviced (1..32)
INIT_MASK, 4'hF, irq_mask value written to slave after reset
CNT_WIDTH, 16, width of the emitted-event counter

Ports:
clk  in  1  clock, same domain as slave
reset_n  in  1  reset
avm_address  out  2  slave register address
avm_chipselect  out  1  slave chipselect
avm_write_n  out  1  active-low write strobe
avm_writedata  out  32  write data
avm_readdata  in  32  slave readdata; registered in slave, valid 1 cycle after address driven
irq  in  1  slave interrupt
mask_in  in  WIDTH  new irq_mask value
mask_load  in  1  1-cycle request to write mask_in to slave
evt_valid  out  1  event record valid
evt_ready  in  1  downstream accept
evt_edges  out  WIDTH  captured edges AND current mask
evt_level  out  WIDTH  input level read after clear
evt_count  out  CNT_WIDTH  events emitted since reset, saturating
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: reset_n asynchronous, active-low; clock clk. Outputs at reset: avm_address 0, avm_chipselect 0, avm_write_n 1, avm_writedata 0, evt_valid 0, evt_edges 0, evt_level 0, evt_count 0, busy 1; mask register = INIT_MASK; pending_mask flag 0; state INIT_MASK.
- No waitrequest; every bus access completes in 1 cycle. Reads: address driven in cycle N with chipselect=1, write_n=1; avm_readdata sampled at end of N+1.
- States (one cycle each unless noted):
  - INIT_MASK: address 2, write_n 0, writedata = zero-extended mask. Next: IDLE.
  - IDLE: chipselect 0, write_n 1, address 0. Priority: pending_mask -> INIT_MASK (clear pending_mask); else irq -> RD_EDGE; else stay.
  - RD_EDGE: read address 3. CAP_EDGE: latch avm_readdata[WIDTH-1:0] & mask into edge register; bus idle.
  - CLR: write address 3, writedata 0; irq drops from the following cycle.
  - RD_LVL: read address 0. CAP_LVL: latch avm_readdata[WIDTH-1:0] into level register. If edge register == 0 (spurious or mask changed), go to IDLE without an event; else go to EMIT.
  - EMIT: evt_valid=1, evt_edges/evt_level stable; hold until evt_ready=1. On the accept cycle: evt_valid->0, evt_count+1 (saturating at all-ones), next IDLE.
- Latency: irq seen in IDLE at cycle 0 -> evt_valid high in cycle 6.
- mask_load in IDLE: mask <= mask_in; go to INIT_MASK next cycle, even if irq is high (mask first). mask_load in any other state: mask <= mask_in, pending_mask <= 1. Last value wins. Edge masking in CAP_EDGE uses the mask value current at that cycle.
- Backpressure: while in EMIT, irq is not serviced; new edges accumulate in slave edge_capture and are serviced later (coalesced).
- An edge arriving between RD_EDGE and CLR is cleared and lost; this is accepted, documented behaviour.
- Reset mid-operation: returns to reset state immediately; any in-flight event is discarded; mask reprogrammed to INIT_MASK.

Test Plan:
- Reset release -> exactly one write cycle: address 2, writedata 0x0000000F, write_n 0; then IDLE, busy 0.
- Slave model with edge_capture=4'b0100, level=4'b1011, irq=1, evt_ready=1 -> reads addr 3, clear write addr 3, reads addr 0; evt_valid in cycle 6 with evt_edges 0100, evt_level 1011; evt_count 0->1.
- evt_ready low 10 cycles in EMIT, second edge on bit 0 -> record held stable, no bus activity; after accept, second event evt_edges 0001.
- mask_load with mask_in 4'b0011 during RD_LVL; edge_capture 1000 -> no event from bit 3; after IDLE a write of 0x3 to address 2.
- Edges 1000 with mask changed to 0011 before CAP_EDGE -> clear write issued, no evt_valid, evt_count unchanged.
- CNT_WIDTH=2, 5 events -> evt_count 1,2,3,3,3; reset asserted in EMIT -> evt_valid 0 immediately, INIT_MASK write follows release.
